// File: rtl/telem_pkg.sv
// Shared constants and types for the telemetry word scheduler.
package telem_pkg;

  localparam int TELEM_WORD_W          = 16;
  localparam int TELEM_WORDS_PER_FRAME = 128;

  typedef logic [TELEM_WORD_W-1:0] telem_word_t;

  localparam telem_word_t TELEM_SYNC_WORD = 16'hEB90;
  localparam telem_word_t TELEM_FILL_WORD = 16'hA5A5;

endpackage

// File: rtl/telem_rr_arb.sv
// Combinational round-robin picker: returns the first set request bit
// found when searching upward from ptr+1 and wrapping back to ptr.
module telem_rr_arb
  import telem_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            any
);

  // Two passes: indices above the pointer first, then the wrapped-around part.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[k] && (k > int'(ptr))) begin
        pick[k] = 1'b1;
        any     = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[k] && (k <= int'(ptr))) begin
        pick[k] = 1'b1;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/telem_word_sched.sv
// Telemetry word scheduler and NRZ serializer. Each frame starts with a
// sync word; data slots go to requesters by round-robin with a burst limit,
// unclaimed slots carry the fill word.
// Optional macro TELEM_FRAME_CNT_EN: slot 1 of every frame carries the
// frame counter instead of requester data.
module telem_word_sched
  import telem_pkg::*;
#(
  parameter int          NREQ            = 2,
  parameter int          MAX_BURST       = 8,
  parameter telem_word_t SYNC_WORD       = TELEM_SYNC_WORD,
  parameter telem_word_t FILL_WORD       = TELEM_FILL_WORD,
  parameter int          WORDS_PER_FRAME = TELEM_WORDS_PER_FRAME
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         bitce_i,
  input  logic                         wordce_i,
  input  logic                         syncce_i,
  input  logic [NREQ-1:0]              req_valid_i,
  input  logic [TELEM_WORD_W*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]              req_ready_o,
  output logic                         sdat_o,
  output logic                         locked_o,
  output logic [NREQ-1:0]              grant_o,
  output logic                         fill_o,
  output logic [6:0]                   word_idx_o,
  output logic [15:0]                  frame_cnt_o,
  output logic                         sync_err_o
);

  localparam int         PW          = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int         BW          = $clog2(MAX_BURST + 1);
  localparam logic [6:0] LAST_IDX    = 7'(WORDS_PER_FRAME - 1);
  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]      state;
  telem_word_t     sr;
  logic [NREQ-1:0] owner;
  logic [BW-1:0]   burst;
  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] grant_q;
  logic            fill_q;
  logic [6:0]      word_idx_q;
  logic [15:0]     frame_cnt_q;
  logic            sync_err_q;

  logic            slot_ev;
  logic            fc_slot;
  logic            cont;
  logic            arb_any;
  logic [NREQ-1:0] arb_pick;
  logic [NREQ-1:0] sel;
  logic [PW-1:0]   pick_idx;
  telem_word_t     sel_word;
  logic [6:0]      next_idx;

  // A data slot is a bit-qualified word strobe without sync while locked.
  assign slot_ev  = (state == ST_LOCKED) && bitce_i && wordce_i && !syncce_i;
  assign next_idx = (word_idx_q == LAST_IDX) ? 7'd0 : word_idx_q + 7'd1;

`ifdef TELEM_FRAME_CNT_EN
  assign fc_slot = (next_idx == 7'd1);
`else
  assign fc_slot = 1'b0;
`endif

  assign cont = (|(owner & req_valid_i)) && (burst < BW'(MAX_BURST));

  telem_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req  (req_valid_i),
    .ptr  (rr_ptr),
    .pick (arb_pick),
    .any  (arb_any)
  );

  // Slot winner: continuing owner, else round-robin pick, else nobody (fill).
  always_comb begin
    sel      = '0;
    sel_word = FILL_WORD;
    pick_idx = '0;
    if (!fc_slot) begin
      if (cont) begin
        sel = owner;
      end else if (arb_any) begin
        sel = arb_pick;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (sel[k]) begin
        sel_word = req_data_i[k*TELEM_WORD_W +: TELEM_WORD_W];
      end
      if (arb_pick[k]) begin
        pick_idx = PW'(k);
      end
    end
  end

  assign req_ready_o = slot_ev ? sel : '0;

  assign sdat_o      = sr[TELEM_WORD_W-1];
  assign locked_o    = (state == ST_LOCKED);
  assign grant_o     = grant_q;
  assign fill_o      = fill_q;
  assign word_idx_o  = word_idx_q;
  assign frame_cnt_o = frame_cnt_q;
  assign sync_err_o  = sync_err_q;

  // Framing, slot ownership and shift register, all advanced only on bit strobes.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= ST_UNLOCKED;
      sr          <= '0;
      owner       <= '0;
      burst       <= '0;
      rr_ptr      <= '0;
      grant_q     <= '0;
      fill_q      <= 1'b0;
      word_idx_q  <= '0;
      frame_cnt_q <= '0;
      sync_err_q  <= 1'b0;
    end else if (bitce_i) begin
      if (syncce_i) begin
        sr         <= SYNC_WORD;
        grant_q    <= '0;
        fill_q     <= 1'b0;
        word_idx_q <= '0;
        if (state == ST_UNLOCKED) begin
          state       <= ST_LOCKED;
          frame_cnt_q <= '0;
        end else begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
          if (word_idx_q != LAST_IDX) begin
            sync_err_q <= 1'b1;
          end
        end
      end else if (wordce_i) begin
        if (state == ST_LOCKED) begin
          word_idx_q <= next_idx;
          grant_q    <= sel;
          if (word_idx_q == LAST_IDX) begin
            sync_err_q <= 1'b1;
          end
          if (fc_slot) begin
            sr     <= frame_cnt_q;
            fill_q <= 1'b0;
          end else begin
            sr     <= sel_word;
            fill_q <= ~|sel;
            if (cont) begin
              burst <= burst + BW'(1);
            end else if (arb_any) begin
              owner  <= arb_pick;
              burst  <= BW'(1);
              rr_ptr <= pick_idx;
            end else begin
              owner <= '0;
            end
          end
        end
      end else begin
        sr <= {sr[TELEM_WORD_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_telem_word_sched.sv
// Directed self-checking bench for telem_word_sched (NREQ=2, MAX_BURST=8).
// Expectations for slot 1 follow TELEM_FRAME_CNT_EN when it is defined.
module tb_telem_word_sched;

`ifdef TELEM_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bitce, wordce, syncce;
  logic [1:0]  req_valid;
  logic [31:0] req_data;
  logic [1:0]  req_ready;
  logic        sdat, locked, fill;
  logic [1:0]  grant;
  logic [6:0]  word_idx;
  logic [15:0] frame_cnt;
  logic        sync_err;

  int num_checks = 0;
  int num_errors = 0;
  int spurious   = 0;

  logic [15:0] cap_word;
  logic [1:0]  cap_grant;
  logic        cap_fill;
  logic [6:0]  cap_idx;
  logic [1:0]  end_ready;

  telem_word_sched dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bitce_i     (bitce),
    .wordce_i    (wordce),
    .syncce_i    (syncce),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .sdat_o      (sdat),
    .locked_o    (locked),
    .grant_o     (grant),
    .fill_o      (fill),
    .word_idx_o  (word_idx),
    .frame_cnt_o (frame_cnt),
    .sync_err_o  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One word period: 16 bit strobes, wordce (and optionally syncce) on the last.
  // Captures the word shifting out during this period and the ready at its end.
  task automatic applyStimulus(input logic sync);
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      cap_word[15-b] = sdat;
      if (b == 0) begin
        cap_grant = grant;
        cap_fill  = fill;
        cap_idx   = word_idx;
      end
      bitce  = 1'b1;
      wordce = (b == 15);
      syncce = sync && (b == 15);
      #1;
      if (b == 15) end_ready = req_ready;
      else if (req_ready != 2'b00) spurious++;
      @(posedge clk);
      #1;
      bitce  = 1'b0;
      wordce = 1'b0;
      syncce = 1'b0;
    end
  endtask

  task automatic bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bitce = 1'b1;
      @(posedge clk);
      #1;
      bitce = 1'b0;
    end
  endtask

  task automatic expect_slot(input string tag, input logic [15:0] w, input logic [1:0] g,
                             input logic f, input logic [6:0] idx);
    checkOutput({tag, "_word"}, 32'(cap_word), 32'(w));
    checkOutput({tag, "_grant"}, 32'(cap_grant), 32'(g));
    checkOutput({tag, "_fill"}, 32'(cap_fill), 32'(f));
    checkOutput({tag, "_idx"}, 32'(cap_idx), 32'(idx));
  endtask

  function automatic logic [1:0] burst_owner(input int slot);
    return ((((slot - 2) / 8) % 2) == 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [15:0] owner_word(input logic [1:0] g);
    return (g == 2'b10) ? 16'h2222 : 16'h1111;
  endfunction

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_sdat"}, 32'(sdat), 32'd0);
    checkOutput({tag, "_locked"}, 32'(locked), 32'd0);
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_fill"}, 32'(fill), 32'd0);
    checkOutput({tag, "_idx"}, 32'(word_idx), 32'd0);
    checkOutput({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    checkOutput({tag, "_err"}, 32'(sync_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]  f2_rdy [5];
    logic [15:0] f2_word[5];
    logic [1:0]  f2_gnt [5];
    logic [1:0]  g;

    rst_n     = 1'b0;
    bitce     = 1'b0;
    wordce    = 1'b0;
    syncce    = 1'b0;
    req_valid = 2'b11;
    req_data  = {16'h2222, 16'h1111};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Unlocked: word strobes ignored, no ready, line stays low
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0);
      checkOutput("unlocked_sdat", 32'(cap_word), 32'd0);
      checkOutput("unlocked_locked", 32'(locked), 32'd0);
      checkOutput("unlocked_ready", 32'(end_ready), 32'd0);
    end
    req_valid = 2'b00;
    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("lock_locked", 32'(locked), 32'd1);
    checkOutput("lock_fcnt", 32'(frame_cnt), 32'd0);
    checkOutput("lock_idx", 32'(word_idx), 32'd0);

    // Frame 0: idle, every data slot is fill (slot 1 may be the frame count)
    for (int s = 1; s <= 127; s++) begin
      applyStimulus(1'b0);
      if (s == 1) begin
        expect_slot("lock_sync", 16'hEB90, 2'b00, 1'b0, 7'd0);
        // Strobes without bitce must be ignored
        @(negedge clk);
        bitce  = 1'b0;
        wordce = 1'b1;
        syncce = 1'b1;
        #1;
        checkOutput("stray_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        wordce = 1'b0;
        syncce = 1'b0;
        @(negedge clk);
        checkOutput("stray_idx", 32'(word_idx), 32'd1);
        checkOutput("stray_fcnt", 32'(frame_cnt), 32'd0);
      end else begin
        expect_slot("idle", (FC_EN && s == 2) ? 16'h0000 : 16'hA5A5, 2'b00,
                    (FC_EN && s == 2) ? 1'b0 : 1'b1, 7'(s - 1));
      end
      checkOutput("idle_ready", 32'(end_ready), 32'd0);
    end
    applyStimulus(1'b1);
    expect_slot("idle_last", 16'hA5A5, 2'b00, 1'b1, 7'd127);
    checkOutput("f1_sync_ready", 32'(end_ready), 32'd0);
    @(negedge clk);
    checkOutput("f1_fcnt", 32'(frame_cnt), 32'd1);
    checkOutput("f1_err", 32'(sync_err), 32'd0);

    // Frame 1: both requesters valid from slot 2, bursts of 8 alternate
    applyStimulus(1'b0);
    expect_slot("f1_sync", 16'hEB90, 2'b00, 1'b0, 7'd0);
    checkOutput("f1_s1_ready", 32'(end_ready), 32'd0);
    req_valid = 2'b11;
    for (int s = 2; s <= 33; s++) begin
      applyStimulus(1'b0);
      checkOutput("burst_ready", 32'(end_ready), 32'(burst_owner(s)));
      if (s == 2) begin
        expect_slot("f1_s1", FC_EN ? 16'h0001 : 16'hA5A5, 2'b00, FC_EN ? 1'b0 : 1'b1, 7'd1);
      end else begin
        g = burst_owner(s - 1);
        expect_slot("burst", owner_word(g), g, 1'b0, 7'(s - 1));
      end
    end
    req_valid = 2'b00;
    applyStimulus(1'b0);
    expect_slot("burst_last", 16'h1111, 2'b01, 1'b0, 7'd33);
    checkOutput("drop_ready", 32'(end_ready), 32'd0);
    for (int s = 35; s <= 122; s++) applyStimulus(1'b0);
    req_valid = 2'b01;
    for (int s = 123; s <= 127; s++) begin
      applyStimulus(1'b0);
      checkOutput("pre_sync_ready", 32'(end_ready), 32'd1);
    end
    applyStimulus(1'b1);
    expect_slot("pre_sync_last", 16'h1111, 2'b01, 1'b0, 7'd127);
    checkOutput("sync_no_accept", 32'(end_ready), 32'd0);
    @(negedge clk);
    checkOutput("f2_fcnt", 32'(frame_cnt), 32'd2);
    checkOutput("f2_err", 32'(sync_err), 32'd0);

    // Frame 2: requester 0 entered sync with burst 5, resumes for 3 words
`ifdef TELEM_FRAME_CNT_EN
    f2_rdy  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    f2_word = '{16'hEB90, 16'h0002, 16'h1111, 16'h1111, 16'h1111};
    f2_gnt  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
`else
    f2_rdy  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    f2_word = '{16'hEB90, 16'h1111, 16'h1111, 16'h1111, 16'h2222};
    f2_gnt  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
`endif
    req_valid = 2'b11;
    for (int s = 1; s <= 5; s++) begin
      applyStimulus(1'b0);
      checkOutput("resume_ready", 32'(end_ready), 32'(f2_rdy[s-1]));
      expect_slot("resume", f2_word[s-1], f2_gnt[s-1], 1'b0, 7'(s - 1));
    end
    req_valid = 2'b00;
    applyStimulus(1'b0);
    expect_slot("resume_tail", 16'h2222, 2'b10, 1'b0, 7'd5);
    for (int s = 7; s <= 50; s++) applyStimulus(1'b0);

    // Early sync at word 50 flags a framing error
    applyStimulus(1'b1);
    expect_slot("early_slot", 16'hA5A5, 2'b00, 1'b1, 7'd50);
    @(negedge clk);
    checkOutput("early_err", 32'(sync_err), 32'd1);
    checkOutput("early_fcnt", 32'(frame_cnt), 32'd3);
    checkOutput("early_idx", 32'(word_idx), 32'd0);

    // Frame 3: slot 1 carries the frame count or requester data
    req_valid = 2'b01;
    req_data  = {16'h2222, 16'h3C3C};
    applyStimulus(1'b0);
    expect_slot("f3_sync", 16'hEB90, 2'b00, 1'b0, 7'd0);
    checkOutput("f3_s1_ready", 32'(end_ready), FC_EN ? 32'd0 : 32'd1);
    applyStimulus(1'b0);
    expect_slot("f3_s1", FC_EN ? 16'h0003 : 16'h3C3C, FC_EN ? 2'b00 : 2'b01, 1'b0, 7'd1);
    checkOutput("f3_s2_ready", 32'(end_ready), 32'd1);
    checkOutput("err_sticky", 32'(sync_err), 32'd1);
    checkOutput("spurious_ready", 32'(spurious), 32'd0);

    // Reset mid-word clears everything
    bits(5);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    bitce  = 1'b1;
    wordce = 1'b1;
    #1;
    checkOutput("midreset_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    bitce  = 1'b0;
    wordce = 1'b0;

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
